// File: rtl/eq_entry_ctrl_if.sv
// Operand/button/result bundle for the equality entry controller.
// The DUT attaches through slave; the environment driving the buttons uses master.
interface eq_entry_ctrl_if;
    logic [3:0] no;
    logic       push1;
    logic       push2;
    logic       ledpin;
    logic [1:0] state;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       done;

    modport slave  (input  no, push1, push2,
                    output ledpin, state, a_q, b_q, done);
    modport master (output no, push1, push2,
                    input  ledpin, state, a_q, b_q, done);
endinterface

// File: rtl/eq_entry_ctrl.sv
// Two-button operand capture: debounced press1 loads A, press2 loads B and
// shows A==B on ledpin for HOLD_CYCLES cycles.
module eq_entry_ctrl #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    eq_entry_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, WAIT_B = 2'b01, SHOW = 2'b10} state_e;

    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q, lvl_q, lvl_prev_q;
    logic [1:0][7:0] cnt_q;
    logic [1:0]      press;

    state_e      state_q, state_d;
    logic [3:0]  cap_a_q, cap_a_d, cap_b_q, cap_b_d;
    logic        led_q, led_d, done_q, done_d;
    logic [15:0] hold_q, hold_d;

    assign raw = {bus.push2, bus.push1};

    // Index 0 is push1, index 1 is push2; each has its own synchronizer and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 8'(DB_CYCLES - 1)) begin
                    lvl_q[i] <= ~lvl_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Rising edge of the debounced level only; releases are silent.
    assign press = lvl_q & ~lvl_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cap_a_q <= '0;
            cap_b_q <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cap_a_q <= cap_a_d;
            cap_b_q <= cap_b_d;
            led_q   <= led_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_a_d = cap_a_q;
        cap_b_d = cap_b_q;
        led_d   = led_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press[0]) begin
                    cap_a_d = bus.no;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                // press2 wins a tie, leaving A untouched.
                if (press[1]) begin
                    cap_b_d = bus.no;
                    led_d   = (cap_a_q == bus.no);
                    hold_d  = 16'(HOLD_CYCLES - 1);
                    done_d  = 1'b1;
                    state_d = SHOW;
                end else if (press[0]) begin
                    cap_a_d = bus.no;
                end
            end
            SHOW: begin
                if (press[0]) begin
                    cap_a_d = bus.no;
                    led_d   = 1'b0;
                    state_d = WAIT_B;
                end else if (hold_q == '0) begin
                    led_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q - 16'd1;
                end
            end
            default: begin
                led_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.state  = state_q;
    assign bus.a_q    = cap_a_q;
    assign bus.b_q    = cap_b_q;
    assign bus.ledpin = led_q;
    assign bus.done   = done_q;
endmodule
